lsu_mem_ctrl: RTL and testbench



---
 rtl/lsu_mem_ctrl_pkg.sv | 23 ++
 rtl/lsu_mem_ctrl_if.sv | 32 +++
 rtl/lsu_mem_ctrl_addr_check.sv | 30 +++
 rtl/lsu_mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the LEGv8 load/store controller.
// Read by lsu_mem_ctrl and lsu_addr_check; see lsu_mem_ctrl.sv for LSU_ALIGN_CHECK_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam int WORD_BITS        = 64;
    localparam int BYTE_OFFSET_BITS = 3;
    localparam int MEM_WORDS_DEF    = 32;
    localparam int MAX_LAT          = 4;
    localparam int CNT_BITS         = 2;

    // Byte address to RAM word index (drops the byte-in-word offset).
    function automatic logic [WORD_BITS-1:0] byte_to_word(input logic [WORD_BITS-1:0] addr);
        return {{BYTE_OFFSET_BITS{1'b0}}, addr[WORD_BITS-1:BYTE_OFFSET_BITS]};
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-RAM signal bundle for the load/store controller.
// slave = controller side, master = requester plus RAM side.
interface lsu_mem_ctrl_if
    import lsu_pkg::*;
();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [WORD_BITS-1:0] req_addr;
    logic [WORD_BITS-1:0] req_wdata;
    logic                 rsp_valid;
    logic [WORD_BITS-1:0] rsp_rdata;
    logic                 rsp_fault;
    logic                 busy;
    logic [WORD_BITS-1:0] mem_address;
    logic                 mem_read_en;
    logic                 mem_write_en;
    logic [WORD_BITS-1:0] mem_data_in;
    logic [WORD_BITS-1:0] mem_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
               mem_address, mem_read_en, mem_write_en, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
               mem_address, mem_read_en, mem_write_en, mem_data_in
    );
endinterface

// File: rtl/lsu_mem_ctrl_addr_check.sv
// Combinational address decode: word index plus range / optional alignment fault.
// Alignment fault only when LSU_ALIGN_CHECK_EN is defined.
module lsu_addr_check
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic [WORD_BITS-1:0] i_addr,
    output logic [WORD_BITS-1:0] o_word_idx,
    output logic                 o_fault
);

    localparam logic [WORD_BITS-1:0] BYTE_LIMIT = WORD_BITS'(MEM_WORDS) << BYTE_OFFSET_BITS;

    logic w_range_fault;
    logic w_align_fault;

    // Fault decode and word index.
    always_comb begin
        w_range_fault = (i_addr >= BYTE_LIMIT);
`ifdef LSU_ALIGN_CHECK_EN
        w_align_fault = |i_addr[BYTE_OFFSET_BITS-1:0];
`else
        w_align_fault = 1'b0;
`endif
        o_fault    = w_range_fault | w_align_fault;
        o_word_idx = byte_to_word(i_addr);
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LDUR/STUR controller sequencing every data-RAM access; all outputs registered.
// Optional LSU_ALIGN_CHECK_EN adds a misalignment fault.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS  = MEM_WORDS_DEF,
    parameter int RD_LATENCY = 1,
    parameter int WR_HOLD    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);

    localparam logic [CNT_BITS-1:0] RD_LAST = CNT_BITS'(RD_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] WR_LAST = CNT_BITS'(WR_HOLD - 1);

    lsu_state_e           r_state, w_state;
    logic [CNT_BITS-1:0]  r_cnt, w_cnt;
    logic                 r_req_ready, w_req_ready;
    logic                 r_busy, w_busy;
    logic                 r_rsp_valid, w_rsp_valid;
    logic [WORD_BITS-1:0] r_rsp_rdata, w_rsp_rdata;
    logic                 r_rsp_fault, w_rsp_fault;
    logic [WORD_BITS-1:0] r_mem_address, w_mem_address;
    logic                 r_mem_read_en, w_mem_read_en;
    logic                 r_mem_write_en, w_mem_write_en;
    logic [WORD_BITS-1:0] r_mem_data_in, w_mem_data_in;

    logic [WORD_BITS-1:0] w_word_idx;
    logic                 w_fault;
    logic                 w_accept;

    lsu_addr_check #(.MEM_WORDS(MEM_WORDS)) u_addr_check (
        .i_addr     (bus.req_addr),
        .o_word_idx (w_word_idx),
        .o_fault    (w_fault)
    );

    assign w_accept = bus.req_valid & r_req_ready;

    // Next-state and next-output logic; enables drop unless re-asserted.
    always_comb begin
        w_state        = r_state;
        w_cnt          = r_cnt;
        w_rsp_rdata    = r_rsp_rdata;
        w_rsp_fault    = r_rsp_fault;
        w_mem_address  = r_mem_address;
        w_mem_data_in  = r_mem_data_in;
        w_mem_read_en  = 1'b0;
        w_mem_write_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_state     = RESP;
                        w_rsp_fault = 1'b1;
                        w_rsp_rdata = {WORD_BITS{1'b0}};
                    end else if (bus.req_write) begin
                        w_state        = WR;
                        w_cnt          = {CNT_BITS{1'b0}};
                        w_mem_address  = w_word_idx;
                        w_mem_data_in  = bus.req_wdata;
                        w_mem_write_en = 1'b1;
                    end else begin
                        w_state       = RD;
                        w_cnt         = {CNT_BITS{1'b0}};
                        w_mem_address = w_word_idx;
                        w_mem_read_en = 1'b1;
                    end
                end else begin
                    w_state = IDLE;
                end
            end
            RD: begin
                if (r_cnt == RD_LAST) begin
                    w_state     = RESP;
                    w_rsp_rdata = bus.mem_out;
                    w_rsp_fault = 1'b0;
                end else begin
                    w_cnt         = r_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
                    w_mem_read_en = 1'b1;
                end
            end
            WR: begin
                if (r_cnt == WR_LAST) begin
                    w_state     = RESP;
                    w_rsp_rdata = {WORD_BITS{1'b0}};
                    w_rsp_fault = 1'b0;
                end else begin
                    w_cnt          = r_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
                    w_mem_write_en = 1'b1;
                end
            end
            RESP: begin
                w_state = IDLE;
                w_cnt   = {CNT_BITS{1'b0}};
            end
            default: begin
                w_state = IDLE;
                w_cnt   = {CNT_BITS{1'b0}};
            end
        endcase
        w_req_ready = (w_state == IDLE);
        w_busy      = (w_state != IDLE);
        w_rsp_valid = (w_state == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= {CNT_BITS{1'b0}};
            r_req_ready    <= 1'b1;
            r_busy         <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= {WORD_BITS{1'b0}};
            r_rsp_fault    <= 1'b0;
            r_mem_address  <= {WORD_BITS{1'b0}};
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_mem_data_in  <= {WORD_BITS{1'b0}};
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_req_ready    <= w_req_ready;
            r_busy         <= w_busy;
            r_rsp_valid    <= w_rsp_valid;
            r_rsp_rdata    <= w_rsp_rdata;
            r_rsp_fault    <= w_rsp_fault;
            r_mem_address  <= w_mem_address;
            r_mem_read_en  <= w_mem_read_en;
            r_mem_write_en <= w_mem_write_en;
            r_mem_data_in  <= w_mem_data_in;
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.busy         = r_busy;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.rsp_fault    = r_rsp_fault;
    assign bus.mem_address  = r_mem_address;
    assign bus.mem_read_en  = r_mem_read_en;
    assign bus.mem_write_en = r_mem_write_en;
    assign bus.mem_data_in  = r_mem_data_in;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: default instance plus an RD_LATENCY=3 instance for reset abort.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic        fault;
        logic [63:0] rdata;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst3_n;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if u_bus1 ();
    lsu_mem_ctrl_if u_bus3 ();

    lsu_mem_ctrl #(.MEM_WORDS(32), .RD_LATENCY(1), .WR_HOLD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus1.slave)
    );

    lsu_mem_ctrl #(.MEM_WORDS(32), .RD_LATENCY(3), .WR_HOLD(1)) dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (u_bus3.slave)
    );

    logic [63:0] ram [32];
    exp_t        sb [$];
    exp_t        e_cur;
    int total = 0, bad = 0;
    int cyc = 0;
    int en_cnt = 0, wr_cnt = 0, both_cnt = 0, rsp3_cnt = 0;
    logic [63:0] last_rd_addr = 64'd0, last_wr_addr = 64'd0;

    assign u_bus1.mem_out = u_bus1.mem_read_en ? ram[u_bus1.mem_address[4:0]] : 64'd0;
    assign u_bus3.mem_out = ram[u_bus3.mem_address[4:0]];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (u_bus1.mem_write_en) ram[u_bus1.mem_address[4:0]] <= u_bus1.mem_data_in;
    end

    always @(negedge clk) begin
        if (u_bus1.mem_read_en | u_bus1.mem_write_en) en_cnt++;
        if (u_bus1.mem_read_en & u_bus1.mem_write_en) both_cnt++;
        if (u_bus1.mem_read_en) last_rd_addr = u_bus1.mem_address;
        if (u_bus1.mem_write_en) begin
            wr_cnt++;
            last_wr_addr = u_bus1.mem_address;
        end
        if (u_bus3.rsp_valid) rsp3_cnt++;
        if (u_bus1.rsp_valid) begin
            if (sb.size() == 0) begin
                check_val("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e_cur = sb.pop_front();
                check_val("rsp_fault", {63'd0, u_bus1.rsp_fault}, {63'd0, e_cur.fault});
                check_val("rsp_rdata", u_bus1.rsp_rdata, e_cur.rdata);
                check_val("rsp_latency", 64'(cyc - e_cur.acc_cyc), 64'(e_cur.lat));
            end
        end
    end

    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic exp_fault, input logic [63:0] exp_rdata, input int lat);
        int n;
        exp_t e;
        @(negedge clk);
        u_bus1.req_valid = 1'b1;
        u_bus1.req_write = wr;
        u_bus1.req_addr  = addr;
        u_bus1.req_wdata = wdata;
        n = 0;
        while (!u_bus1.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("ready_timeout", 64'd0, 64'd1);
        e.fault = exp_fault; e.rdata = exp_rdata; e.acc_cyc = cyc; e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1 u_bus1.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || !u_bus1.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int acc;
        int n;
        int base;
        exp_t e;
        for (int i = 0; i < 32; i++) ram[i] = 64'(i * 100);
        rst_n = 1'b0; rst3_n = 1'b0;
        u_bus1.req_valid = 1'b0; u_bus1.req_write = 1'b0;
        u_bus1.req_addr = 64'd0; u_bus1.req_wdata = 64'd0;
        u_bus3.req_valid = 1'b0; u_bus3.req_write = 1'b0;
        u_bus3.req_addr = 64'd0; u_bus3.req_wdata = 64'd0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {63'd0, u_bus1.req_ready}, 64'd1);
        check_val("rst_busy", {63'd0, u_bus1.busy}, 64'd0);
        check_val("rst_rsp_valid", {63'd0, u_bus1.rsp_valid}, 64'd0);
        check_val("rst_rsp_fault", {63'd0, u_bus1.rsp_fault}, 64'd0);
        check_val("rst_rsp_rdata", u_bus1.rsp_rdata, 64'd0);
        check_val("rst_read_en", {63'd0, u_bus1.mem_read_en}, 64'd0);
        check_val("rst_write_en", {63'd0, u_bus1.mem_write_en}, 64'd0);
        check_val("rst_address", u_bus1.mem_address, 64'd0);
        check_val("rst_data_in", u_bus1.mem_data_in, 64'd0);
        rst_n = 1'b1; rst3_n = 1'b1;

        do_req(1'b0, 64'h28, 64'd0, 1'b0, 64'd500, 2);
        wait_done();
        check_val("load_addr_0x28", last_rd_addr, 64'd5);

        base = wr_cnt;
        do_req(1'b1, 64'h10, 64'hDEAD, 1'b0, 64'd0, 2);
        wait_done();
        check_val("store_wr_cycles", 64'(wr_cnt - base), 64'd1);
        check_val("store_addr", last_wr_addr, 64'd2);
        do_req(1'b0, 64'h10, 64'd0, 1'b0, 64'hDEAD, 2);
        wait_done();
        repeat (3) @(negedge clk);
        check_val("rdata_hold", u_bus1.rsp_rdata, 64'hDEAD);

        base = en_cnt;
        do_req(1'b0, 64'h100, 64'd0, 1'b1, 64'd0, 1);
        wait_done();
        repeat (2) @(negedge clk);
        check_val("fault_no_enable", 64'(en_cnt - base), 64'd0);
        check_val("fault_hold", {63'd0, u_bus1.rsp_fault}, 64'd1);

        do_req(1'b0, 64'hF8, 64'd0, 1'b0, 64'd3100, 2);
        wait_done();

`ifdef LSU_ALIGN_CHECK_EN
        base = en_cnt;
        do_req(1'b0, 64'h0C, 64'd0, 1'b1, 64'd0, 1);
        wait_done();
        check_val("misalign_no_enable", 64'(en_cnt - base), 64'd0);
`else
        do_req(1'b0, 64'h0C, 64'd0, 1'b0, 64'd100, 2);
        wait_done();
`endif

        base = wr_cnt;
        do_req(1'b1, 64'h100, 64'h1234, 1'b1, 64'd0, 1);
        wait_done();
        check_val("store_fault_no_write", 64'(wr_cnt - base), 64'd0);

        // Requester holds valid across two transactions.
        acc = 0;
        @(negedge clk);
        u_bus1.req_valid = 1'b1; u_bus1.req_write = 1'b0; u_bus1.req_addr = 64'h28;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check_val("hold_ready", {63'd0, u_bus1.req_ready}, 64'((k % 3) == 0));
            if (u_bus1.req_ready) begin
                acc++;
                e.fault = 1'b0; e.rdata = 64'd500; e.acc_cyc = cyc; e.lat = 2;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        u_bus1.req_valid = 1'b0;
        check_val("hold_accepts", 64'(acc), 64'd2);
        wait_done();

        // RD_LATENCY=3 instance: normal load latency, then reset abort.
        @(negedge clk);
        u_bus3.req_valid = 1'b1; u_bus3.req_write = 1'b0; u_bus3.req_addr = 64'h28;
        @(posedge clk);
        #1 u_bus3.req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_bus3.rsp_valid && n < 10);
        check_val("rl3_latency", 64'(n), 64'd4);
        check_val("rl3_rdata", u_bus3.rsp_rdata, 64'd500);
        repeat (2) @(negedge clk);

        u_bus3.req_valid = 1'b1; u_bus3.req_addr = 64'h30;
        @(posedge clk);
        #1 u_bus3.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rl3_read_en_before_rst", {63'd0, u_bus3.mem_read_en}, 64'd1);
        base = rsp3_cnt;
        rst3_n = 1'b0;
        #1;
        check_val("rl3_read_en_async_drop", {63'd0, u_bus3.mem_read_en}, 64'd0);
        repeat (4) @(negedge clk);
        rst3_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rl3_no_rsp", 64'(rsp3_cnt - base), 64'd0);
        check_val("rl3_ready_after", {63'd0, u_bus3.req_ready}, 64'd1);
        check_val("rl3_busy_after", {63'd0, u_bus3.busy}, 64'd0);

        check_val("enables_exclusive", 64'(both_cnt), 64'd0);
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
